// File: rtl/instruc_encode_pkg.sv
// instruc_encode_pkg
//   Shared encoding constants for the instruction encoder and its matching
//   decoder: mnemonic codes, ALU op codes, control-bit triples, field bit
//   positions, and a small helper classifying Reg_write mnemonics.
package instruc_encode_pkg;

   localparam int INSTR_W = 16;
   localparam int PADDR_W = 8;

   // Request mnemonic codes
   typedef enum logic [3:0] {
      M_ADD  = 4'd0,  M_SUB  = 4'd1,  M_MULT = 4'd2,  M_DIV  = 4'd3,
      M_AND  = 4'd4,  M_OR   = 4'd5,  M_XOR  = 4'd6,
      M_ADDI = 4'd7,  M_SUBI = 4'd8,  M_MULTI= 4'd9,  M_DIVI = 4'd10,
      M_ANDI = 4'd11, M_ORI  = 4'd12, M_XORI = 4'd13,
      M_SAVE = 4'd14, M_LOAD = 4'd15
   } mnem_e;

   // ALU op field [15:13]
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MULT = 3'b010, OP_DIV = 3'b011,
      OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR  = 3'b110, OP_MEM = 3'b111
   } alu_op_e;

   // Control triples {Reg_write, Mem_write, Reg_src_cntrl}
   localparam logic [2:0] CTRL_ALU  = 3'b100;
   localparam logic [2:0] CTRL_SAVE = 3'b010;
   localparam logic [2:0] CTRL_LOAD = 3'b101;

   // Field bit positions
   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 13;
   localparam int IMM_BIT  = 12;
   localparam int CTRL_MSB = 11;
   localparam int CTRL_LSB = 9;
   localparam int F1_MSB   = 8;   // rd (ALU words)
   localparam int F1_LSB   = 6;
   localparam int F2_MSB   = 5;   // rs / imm
   localparam int F2_LSB   = 3;
   localparam int F3_MSB   = 2;   // rt / rs / memory register
   localparam int F3_LSB   = 0;
   localparam int MADDR_MSB = 8;  // data-memory address in SAVE/LOAD
   localparam int MADDR_LSB = 3;

   // Every mnemonic except SAVE writes a register.
   function automatic logic writes_reg(input logic [3:0] m);
      return (m != M_SAVE);
   endfunction

endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2
//   Two-entry first-in first-out buffer for encoded words. Head data is
//   driven straight from storage, so it stays stable until popped.
//   Ports: clk, rst_n; push_i/data_i (write side, caller honours full_o);
//   pop_i (caller honours empty_o); data_o head word; full_o, empty_o.
module instr_fifo2 #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [1:0][W-1:0] mem_q;
   logic              wr_q, rd_q;
   logic [1:0]        cnt_q;

   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (pop_i)
            rd_q <= ~rd_q;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/instruc_encode.sv
// instruc_encode
//   Encodes mnemonic requests into 16-bit instruction words, queues them in
//   a 2-entry FIFO and tags each emitted word with a program-memory address.
//   Ports: clk, rst_n; in_valid/in_ready + mnem, rd, rs, rt, imm, addr
//   (request); out_valid/out_ready + out_instr, out_addr (result);
//   addr_load/addr_base (program address preset); err (one-cycle pulse per
//   illegal request), err_cnt (saturating illegal-request count).
module instruc_encode
   import instruc_encode_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         mnem,
   input  logic [2:0]         rd,
   input  logic [2:0]         rs,
   input  logic [2:0]         rt,
   input  logic [2:0]         imm,
   input  logic [5:0]         addr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PADDR_W-1:0] out_addr,
   input  logic               addr_load,
   input  logic [PADDR_W-1:0] addr_base,
   output logic               err,
   output logic [7:0]         err_cnt
);

   logic [INSTR_W-1:0] word_d;
   logic               illegal, accept, push, pop, full, empty;
   logic               err_q;
   logic [7:0]         err_cnt_q;
   logic [PADDR_W-1:0] paddr_q;

   // Combinational encode ahead of the FIFO
   always_comb begin
      word_d = '0;
      if (mnem < 4'd7) begin
         word_d[OP_MSB:OP_LSB]     = mnem[2:0];
         word_d[IMM_BIT]           = 1'b0;
         word_d[CTRL_MSB:CTRL_LSB] = CTRL_ALU;
         word_d[F1_MSB:F1_LSB]     = rd;
         word_d[F2_MSB:F2_LSB]     = rs;
         word_d[F3_MSB:F3_LSB]     = rt;
      end else if (mnem < 4'd14) begin
         // Immediate forms share the R-type op ordering, offset by 7.
         word_d[OP_MSB:OP_LSB]     = 3'(mnem - 4'd7);
         word_d[IMM_BIT]           = 1'b1;
         word_d[CTRL_MSB:CTRL_LSB] = CTRL_ALU;
         word_d[F1_MSB:F1_LSB]     = rd;
         word_d[F2_MSB:F2_LSB]     = imm;
         word_d[F3_MSB:F3_LSB]     = rs;
      end else if (mnem == M_SAVE) begin
         word_d[OP_MSB:OP_LSB]       = OP_MEM;
         word_d[CTRL_MSB:CTRL_LSB]   = CTRL_SAVE;
         word_d[MADDR_MSB:MADDR_LSB] = addr;
         word_d[F3_MSB:F3_LSB]       = rs;
      end else begin
         word_d[OP_MSB:OP_LSB]       = OP_MEM;
         word_d[CTRL_MSB:CTRL_LSB]   = CTRL_LOAD;
         word_d[MADDR_MSB:MADDR_LSB] = addr;
         word_d[F3_MSB:F3_LSB]       = rd;
      end
   end

   assign illegal = (writes_reg(mnem) && rd == 3'd0) ||
                    (mnem == M_DIVI && imm == 3'd0);
   assign accept  = in_valid & in_ready;
   assign push    = accept & ~illegal;   // illegal requests are consumed, never queued
   assign pop     = out_valid & out_ready;

   assign in_ready  = ~full;
   assign out_valid = ~empty;

   instr_fifo2 #(.W(INSTR_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (word_d),
      .pop_i   (pop),
      .data_o  (out_instr),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
         paddr_q   <= '0;
      end else begin
         err_q <= accept & illegal;
         if (accept && illegal && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
         // A preset takes priority over the post-pop increment.
         if (addr_load)
            paddr_q <= addr_base;
         else if (pop)
            paddr_q <= paddr_q + 1'b1;
      end
   end

   assign err      = err_q;
   assign err_cnt  = err_cnt_q;
   assign out_addr = paddr_q;

endmodule

// File: tb/tb_instruc_encode.sv
module tb_instruc_encode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [3:0]  mnem;
   logic [2:0]  rd, rs, rt, imm;
   logic [5:0]  addr;
   logic        out_valid, out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_addr;
   logic        addr_load;
   logic [7:0]  addr_base;
   logic        err;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] instr;
      logic [7:0]  paddr;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   instruc_encode dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mnem      (mnem),
      .rd        (rd),
      .rs        (rs),
      .rt        (rt),
      .imm       (imm),
      .addr      (addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .addr_load (addr_load),
      .addr_base (addr_base),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   // Scoreboard: a pop happens on the next rising edge, so the values seen
   // on the falling edge are the ones transferred.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_pop instr=%h addr=%0d expected no word", out_instr, out_addr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            assert (out_instr === e.instr) else begin
               errors++;
               $error("FAIL sb_instr got=%h exp=%h", out_instr, e.instr);
            end
            checks++;
            assert (out_addr === e.paddr) else begin
               errors++;
               $error("FAIL sb_addr got=%0d exp=%0d", out_addr, e.paddr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] m, input logic [2:0] r_d, input logic [2:0] r_s,
                       input logic [2:0] r_t, input logic [2:0] im, input logic [5:0] a,
                       input logic push, input logic [15:0] ei, input logic [7:0] ea);
      mnem = m; rd = r_d; rs = r_s; rt = r_t; imm = im; addr = a;
      in_valid = 1'b1;
      for (int n = 0; n < 50 && !in_ready; n++) tick();
      checks++;
      assert (in_ready === 1'b1) else begin
         errors++;
         $error("FAIL send_timeout got=%b exp=1", in_ready);
      end
      if (push) sb.push_back('{instr: ei, paddr: ea});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load(input logic [7:0] b);
      addr_load = 1'b1;
      addr_base = b;
      tick();
      addr_load = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && sb.size() != 0; n++) tick();
      checks++;
      assert (sb.size() === 0) else begin
         errors++;
         $error("FAIL drain_timeout got=%0d exp=0 words pending", sb.size());
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mnem = '0; rd = '0; rs = '0; rt = '0; imm = '0; addr = '0;
      addr_load = 1'b0; addr_base = '0;
      #1;
      // Reset state
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_in_ready",  16'(in_ready),  16'd1);
      chk("rst_out_instr", out_instr,      16'h0000);
      chk("rst_out_addr",  16'(out_addr),  16'd0);
      chk("rst_err",       16'(err),       16'd0);
      chk("rst_err_cnt",   16'(err_cnt),   16'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Scenario 1: ADD visible one cycle after acceptance
      out_ready = 1'b1;
      send(4'd0, 3'd6, 3'd2, 3'd3, 3'd0, 6'd0, 1'b1, 16'h0993, 8'd0);
      chk("s1_valid", 16'(out_valid), 16'd1);
      chk("s1_instr", out_instr, 16'h0993);
      drain();

      // Scenario 2: SUBI, SAVE, LOAD back to back
      load(8'd0);
      send(4'd8,  3'd1, 3'd4, 3'd0, 3'd2, 6'd0,  1'b1, 16'h3854, 8'd0);
      send(4'd14, 3'd0, 3'd2, 3'd0, 3'd0, 6'd50, 1'b1, 16'hE592, 8'd1);
      send(4'd15, 3'd4, 3'd0, 3'd0, 3'd0, 6'd14, 1'b1, 16'hEA74, 8'd2);
      drain();

      // Scenario 3: backpressure fills the FIFO
      out_ready = 1'b0;
      send(4'd0, 3'd1, 3'd2, 3'd3, 3'd0, 6'd0, 1'b1, 16'h0853, 8'd3);
      send(4'd6, 3'd7, 3'd7, 3'd7, 3'd0, 6'd0, 1'b1, 16'hC9FF, 8'd4);
      chk("s3_full_ready", 16'(in_ready), 16'd0);
      mnem = 4'd5; rd = 3'd2; rs = 3'd0; rt = 3'd5; in_valid = 1'b1;
      tick(); tick(); tick();
      chk("s3_still_full", 16'(in_ready), 16'd0);
      chk("s3_hold_instr", out_instr, 16'h0853);
      chk("s3_hold_addr",  16'(out_addr), 16'd3);
      out_ready = 1'b1;
      send(4'd5, 3'd2, 3'd0, 3'd5, 3'd0, 6'd0, 1'b1, 16'hA885, 8'd5);
      drain();

      // Scenario 4: illegal requests
      send(4'd0, 3'd0, 3'd1, 3'd1, 3'd0, 6'd0, 1'b0, 16'h0, 8'd0);
      chk("s4_err1",  16'(err),     16'd1);
      chk("s4_cnt1",  16'(err_cnt), 16'd1);
      send(4'd10, 3'd1, 3'd0, 3'd0, 3'd0, 6'd0, 1'b0, 16'h0, 8'd0);
      chk("s4_err2",  16'(err),     16'd1);
      chk("s4_cnt2",  16'(err_cnt), 16'd2);
      tick();
      chk("s4_err_low", 16'(err),       16'd0);
      chk("s4_empty",   16'(out_valid), 16'd0);
      // DIVI with nonzero imm is legal
      send(4'd10, 3'd1, 3'd0, 3'd0, 3'd1, 6'd0, 1'b1, 16'h7848, 8'd6);
      chk("s4_legal_noerr", 16'(err), 16'd0);
      drain();
      // Saturation at 255
      for (int i = 0; i < 260; i++)
         send(4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 6'd1, 1'b0, 16'h0, 8'd0);
      chk("s4_saturate", 16'(err_cnt), 16'd255);
      tick();
      chk("s4_sat_empty", 16'(out_valid), 16'd0);

      // Scenario 5: address preset and wrap
      load(8'd255);
      chk("s5_preset", 16'(out_addr), 16'd255);
      send(4'd9, 3'd3, 3'd1, 3'd0, 3'd7, 6'd0, 1'b1, 16'h58F9, 8'd255);
      send(4'd3, 3'd5, 3'd6, 3'd1, 3'd0, 6'd0, 1'b1, 16'h6971, 8'd0);
      drain();
      out_ready = 1'b0;
      send(4'd4, 3'd4, 3'd3, 3'd2, 3'd0, 6'd0, 1'b1, 16'h891A, 8'd1);
      out_ready = 1'b1;
      load(8'd100);   // coincides with the pop of the AND word
      chk("s5_load_wins", 16'(out_addr), 16'd100);
      // SAVE with rd=0 is legal
      send(4'd14, 3'd0, 3'd1, 3'd0, 3'd0, 6'd0, 1'b1, 16'hE401, 8'd100);
      chk("s5_save_rd0_noerr", 16'(err), 16'd0);
      drain();

      // Scenario 6: reset with the FIFO full
      out_ready = 1'b0;
      send(4'd0, 3'd6, 3'd2, 3'd3, 3'd0, 6'd0, 1'b0, 16'h0, 8'd0);
      send(4'd1, 3'd6, 3'd2, 3'd3, 3'd0, 6'd0, 1'b0, 16'h0, 8'd0);
      chk("s6_full", 16'(in_ready), 16'd0);
      rst_n = 1'b0;
      #1;
      chk("s6_valid",    16'(out_valid), 16'd0);
      chk("s6_ready",    16'(in_ready),  16'd1);
      chk("s6_addr",     16'(out_addr),  16'd0);
      chk("s6_err_cnt",  16'(err_cnt),   16'd0);
      chk("s6_instr",    out_instr,      16'h0000);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(); tick();
      chk("s6_no_ghost", 16'(out_valid), 16'd0);
      send(4'd13, 3'd7, 3'd3, 3'd0, 3'd5, 6'd0, 1'b1, 16'hD9EB, 8'd0);
      drain();

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instruc_encode.md
INSTRUC_ENCODE -- requirements
Module: instruc_encode

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have in_valid  in  1  request carries a mnemonic and fields to encode.
REQ-003 SHALL have in_ready  out  1  block can accept a request this cycle.
REQ-004 SHALL have mnem  in  4  mnemonic code: 0-6 ADD,SUB,MULT,DIV,AND,OR,XOR; 7-13 ADDI..XORI in the same order; 14 SAVE; 15 LOAD.
REQ-005 SHALL have rd, rs, rt, imm  in  3 each  register and immediate fields; addr  in  6  data-memory address.
REQ-006 SHALL have out_valid  out  1; out_ready  in  1; out_instr  out  16  encoded word; out_addr  out  8  program-memory word address.
REQ-007 SHALL have addr_load  in  1; addr_base  in  8  new program address; err  out  1  one-cycle illegal-request pulse; err_cnt  out  8  saturating count of illegal requests.

Function
REQ-008 The encoding SHALL be [15:13] ALU op (ADD 000, SUB 001, MULT 010, DIV 011, AND 100, OR 101, XOR 110, memory 111); [12] immediate flag; [11] Reg_write; [10] Mem_write; [9] Reg_src_cntrl.
REQ-009 R-type words SHALL be op,0,100,rd,rs,rt; I-type words SHALL be op,1,100,rd,imm,rs.
REQ-010 SAVE SHALL encode as 111,0,010,addr,rs; LOAD SHALL encode as 111,0,101,addr,rd.
REQ-011 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-012 An accepted word SHALL enter a 2-entry FIFO and appear at the FIFO head no earlier than the next cycle (1-cycle latency when the FIFO is empty).
REQ-013 in_ready SHALL equal "FIFO not full"; a push and a pop in the same cycle SHALL both take effect.
REQ-014 out_valid SHALL equal "FIFO not empty"; out_instr and out_addr SHALL hold stable while out_valid is high and out_ready is low.
REQ-015 Illegal requests SHALL be consumed without entering the FIFO, SHALL pulse err for one cycle, and SHALL increment err_cnt, which saturates at 255.
REQ-016 Illegal requests are: rd==0 for any Reg_write mnemonic (0-13, 15); and DIVI with imm==0.
REQ-017 out_addr SHALL come from an 8-bit counter that increments on each pop (out_valid and out_ready) and wraps from 255 to 0.
REQ-018 addr_load SHALL set the counter to addr_base on the next edge; if it coincides with a pop, the load SHALL win.
REQ-019 FIFO ordering SHALL be strict first-in, first-out; no entry SHALL be dropped or duplicated.

Reset
REQ-020 On rst_n low: FIFO empty, out_valid=0, in_ready=1, out_instr=0, out_addr=0, err=0, err_cnt=0.
REQ-021 Reset asserted mid-transfer SHALL discard all FIFO contents; no partial word SHALL be emitted after reset is released.

Structure
REQ-022 A shared package SHALL hold the mnemonic codes, the ALU op codes, the control-bit triples (100, 010, 101) and the field bit positions, shared with the decoder.
REQ-023 The 2-entry FIFO SHALL be the single sub-module, named instr_fifo2.
REQ-024 The encode logic SHALL be combinational ahead of the FIFO push.

Verification
REQ-025 Scenario 1: ADD rd=6 rs=2 rt=3 with out_ready=1 -> out_instr=0x0993, out_addr=0, visible one cycle after acceptance.
REQ-026 Scenario 2: SUBI rd=1 rs=4 imm=2, then SAVE rs=2 addr=50, then LOAD rd=4 addr=14 -> 0x3854, 0xE592, 0xEA74 in order, at out_addr 0, 1, 2.
REQ-027 Scenario 3: out_ready=0 and three back-to-back requests -> in_ready falls after two acceptances; first word held stable; releasing out_ready drains both words in order.
REQ-028 Scenario 4: ADD rd=0, then DIVI imm=0 -> two err pulses, err_cnt=2, FIFO stays empty.
REQ-029 Scenario 5: addr_load with addr_base=255, then two pops -> out_addr 255 then 0; a load coinciding with a pop sets the counter to addr_base.
REQ-030 Scenario 6: rst_n pulsed low with the FIFO full -> out_valid=0 immediately, counters 0, next accepted word at out_addr 0.
